// File: rtl/frogger_pkg.sv
// Shared constants for the traffic lanes: playfield bounds, vehicle lengths,
// move periods, car spacing and the sweep FSM encoding.
package frogger_pkg;
    localparam int BLOCKSIZE      = 32;
    localparam int X_OFFSET_LEFT  = 96;
    localparam int X_OFFSET_RIGHT = 544;
    localparam int NUM_LANES      = 6;
    localparam int NUM_CARS       = 3;
    localparam int CAR_SPACING    = 150;
    localparam int LANE_STAGGER   = 24;

    localparam logic [9:0] X_MAX = 10'(X_OFFSET_RIGHT - 1);

    localparam logic [9:0] LANE_LEN [NUM_LANES] =
        '{10'd32, 10'd64, 10'd32, 10'd96, 10'd32, 10'd64};
    localparam logic [3:0] BASE_PERIOD [NUM_LANES] =
        '{4'd4, 4'd3, 4'd2, 4'd4, 4'd3, 4'd2};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UPD0 = 3'd1,
        ST_UPD1 = 3'd2,
        ST_UPD2 = 3'd3,
        ST_UPD3 = 3'd4,
        ST_UPD4 = 3'd5,
        ST_UPD5 = 3'd6
    } state_e;

    function automatic logic [9:0] init_x(input int lane, input int car);
        return 10'(X_OFFSET_LEFT + CAR_SPACING * car + LANE_STAGGER * lane);
    endfunction

    // A fast level can shift the period to zero; a lane never moves faster than once per frame.
    function automatic logic [3:0] lane_period(input logic [3:0] base, input logic [1:0] level);
        logic [3:0] p;
        p = base >> level;
        return (p == 4'd0) ? 4'd1 : p;
    endfunction
endpackage

// File: rtl/car_step.sv
// Next horizontal position of one car: one pixel step with wrap between the
// lane's left bound (96-len) and the right edge (543).
module car_step
    import frogger_pkg::*;
(
    input  logic [9:0] x,
    input  logic [9:0] len,
    input  logic       dir,
    output logic [9:0] nx
);
    logic [9:0] lo;
    assign lo = 10'(X_OFFSET_LEFT) - len;

    always_comb begin
        nx = x;
        if (!dir)
            nx = (x == X_MAX) ? lo : x + 10'd1;
        else
            nx = (x == lo) ? X_MAX : x - 10'd1;
    end
endmodule

// File: rtl/cars_motion.sv
// Traffic mover: on each frame tick sweeps the six lanes, one per cycle,
// stepping a lane's three cars when its frame counter reaches its period.
module cars_motion
    import frogger_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       restart,
    input  logic [1:0] level,
    output logic [9:0] lane0_car0_x,
    output logic [9:0] lane0_car1_x,
    output logic [9:0] lane0_car2_x,
    output logic [9:0] lane1_car0_x,
    output logic [9:0] lane1_car1_x,
    output logic [9:0] lane1_car2_x,
    output logic [9:0] lane2_car0_x,
    output logic [9:0] lane2_car1_x,
    output logic [9:0] lane2_car2_x,
    output logic [9:0] lane3_car0_x,
    output logic [9:0] lane3_car1_x,
    output logic [9:0] lane3_car2_x,
    output logic [9:0] lane4_car0_x,
    output logic [9:0] lane4_car1_x,
    output logic [9:0] lane4_car2_x,
    output logic [9:0] lane5_car0_x,
    output logic [9:0] lane5_car1_x,
    output logic [9:0] lane5_car2_x,
    output logic [9:0] lane0_length,
    output logic [9:0] lane1_length,
    output logic [9:0] lane2_length,
    output logic [9:0] lane3_length,
    output logic [9:0] lane4_length,
    output logic [9:0] lane5_length,
    output logic       busy,
    output logic       overrun
);
    localparam logic [2:0] IDLE = 3'(ST_IDLE);
    localparam logic [2:0] UPD0 = 3'(ST_UPD0);
    localparam logic [2:0] UPD5 = 3'(ST_UPD5);

    logic [2:0] state;
    logic [9:0] pos [NUM_LANES][NUM_CARS];
    logic [3:0] cnt [NUM_LANES];

    logic [2:0] lane;
    logic [9:0] cur_len;
    logic [3:0] cur_p;
    logic [4:0] cnt_inc;
    logic [NUM_CARS-1:0][9:0] nx;

    // The three steppers follow the lane selected by the sweep state.
    assign lane    = (state == IDLE) ? 3'd0 : state - 3'd1;
    assign cur_len = LANE_LEN[lane];
    assign cur_p   = lane_period(BASE_PERIOD[lane], level);
    assign cnt_inc = {1'b0, cnt[lane]} + 5'd1;

    for (genvar g = 0; g < NUM_CARS; g++) begin : g_step
        car_step u_step (
            .x   (pos[lane][g]),
            .len (cur_len),
            .dir (lane[0]),
            .nx  (nx[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state   <= IDLE;
            overrun <= 1'b0;
            for (int n = 0; n < NUM_LANES; n++) begin
                cnt[n] <= 4'd0;
                for (int k = 0; k < NUM_CARS; k++)
                    pos[n][k] <= init_x(n, k);
            end
        end else if (state == IDLE) begin
            if (frame_tick)
                state <= UPD0;
        end else begin
            if (frame_tick)
                overrun <= 1'b1;
            state <= (state == UPD5) ? IDLE : state + 3'd1;
            if (enable) begin
                if (cnt_inc >= {1'b0, cur_p}) begin
                    cnt[lane] <= 4'd0;
                    for (int k = 0; k < NUM_CARS; k++)
                        pos[lane][k] <= nx[k];
                end else begin
                    cnt[lane] <= cnt_inc[3:0];
                end
            end
        end
    end

    assign busy = (state != IDLE);

    assign lane0_car0_x = pos[0][0];
    assign lane0_car1_x = pos[0][1];
    assign lane0_car2_x = pos[0][2];
    assign lane1_car0_x = pos[1][0];
    assign lane1_car1_x = pos[1][1];
    assign lane1_car2_x = pos[1][2];
    assign lane2_car0_x = pos[2][0];
    assign lane2_car1_x = pos[2][1];
    assign lane2_car2_x = pos[2][2];
    assign lane3_car0_x = pos[3][0];
    assign lane3_car1_x = pos[3][1];
    assign lane3_car2_x = pos[3][2];
    assign lane4_car0_x = pos[4][0];
    assign lane4_car1_x = pos[4][1];
    assign lane4_car2_x = pos[4][2];
    assign lane5_car0_x = pos[5][0];
    assign lane5_car1_x = pos[5][1];
    assign lane5_car2_x = pos[5][2];

    assign lane0_length = LANE_LEN[0];
    assign lane1_length = LANE_LEN[1];
    assign lane2_length = LANE_LEN[2];
    assign lane3_length = LANE_LEN[3];
    assign lane4_length = LANE_LEN[4];
    assign lane5_length = LANE_LEN[5];
endmodule

// File: tb/tb_cars_motion.sv
// Self-checking bench for cars_motion against a phase-based lane model.
module tb_cars_motion;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b1;
    logic       restart = 1'b0;
    logic [1:0] level = 2'd0;
    logic [9:0] x [6][3];
    logic [9:0] len_o [6];
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad = 0;

    int LEN  [6] = '{32, 64, 32, 96, 32, 64};
    int BASE [6] = '{4, 3, 2, 4, 3, 2};
    int m_x  [6][3];
    int m_cnt[6];

    always #5 clk = ~clk;

    cars_motion dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .restart(restart), .level(level),
        .lane0_car0_x(x[0][0]), .lane0_car1_x(x[0][1]), .lane0_car2_x(x[0][2]),
        .lane1_car0_x(x[1][0]), .lane1_car1_x(x[1][1]), .lane1_car2_x(x[1][2]),
        .lane2_car0_x(x[2][0]), .lane2_car1_x(x[2][1]), .lane2_car2_x(x[2][2]),
        .lane3_car0_x(x[3][0]), .lane3_car1_x(x[3][1]), .lane3_car2_x(x[3][2]),
        .lane4_car0_x(x[4][0]), .lane4_car1_x(x[4][1]), .lane4_car2_x(x[4][2]),
        .lane5_car0_x(x[5][0]), .lane5_car1_x(x[5][1]), .lane5_car2_x(x[5][2]),
        .lane0_length(len_o[0]), .lane1_length(len_o[1]), .lane2_length(len_o[2]),
        .lane3_length(len_o[3]), .lane4_length(len_o[4]), .lane5_length(len_o[5]),
        .busy(busy), .overrun(overrun)
    );

    function automatic int period(input int n, input int lv);
        int p;
        p = BASE[n] >> lv;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 6; n++) begin
            m_cnt[n] = 0;
            for (int k = 0; k < 3; k++) m_x[n][k] = 96 + 150 * k + 24 * n;
        end
    endtask

    // Each car is a phase on a ring of 448+len positions starting at 96-len.
    task automatic model_frame(input bit en, input int lv);
        int lo, cyc, ph;
        if (!en) return;
        for (int n = 0; n < 6; n++) begin
            if (m_cnt[n] + 1 >= period(n, lv)) begin
                m_cnt[n] = 0;
                lo  = 96 - LEN[n];
                cyc = 448 + LEN[n];
                for (int k = 0; k < 3; k++) begin
                    ph = m_x[n][k] - lo;
                    ph = (ph + ((n % 2 == 0) ? 1 : cyc - 1)) % cyc;
                    m_x[n][k] = lo + ph;
                end
            end else begin
                m_cnt[n] = m_cnt[n] + 1;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // One isolated tick; counts busy samples over the following eight cycles.
    task automatic pulse_tick(output int busy_cnt);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        model_frame(enable, int'(level));
        busy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b want=0", overrun); end
        for (int n = 0; n < 6; n++) begin
            total++;
            if (len_o[n] !== 10'(LEN[n])) begin
                bad++; $display("FAIL length lane%0d got=%0d want=%0d", n, len_o[n], LEN[n]);
            end
            for (int k = 0; k < 3; k++) begin
                total++;
                if (x[n][k] !== 10'(96 + 150 * k + 24 * n)) begin
                    bad++; $display("FAIL reset_x lane%0d car%0d got=%0d want=%0d", n, k, x[n][k], 96 + 150 * k + 24 * n);
                end
            end
        end
    endtask

    task automatic test_basic();
        int bc;
        do_reset();
        level = 2'd0; enable = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            pulse_tick(bc);
            total++;
            if (bc !== 6) begin bad++; $display("FAIL basic_busy tick%0d got=%0d want=6", t, bc); end
            for (int n = 0; n < 6; n++)
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if (x[n][k] !== 10'(m_x[n][k])) begin
                        bad++; $display("FAIL basic_x tick%0d lane%0d car%0d got=%0d want=%0d", t, n, k, x[n][k], m_x[n][k]);
                    end
                end
            if (t == 3) begin
                total++;
                if (x[1][0] !== 10'd119) begin bad++; $display("FAIL basic_lane1 got=%0d want=119", x[1][0]); end
                total++;
                if (x[0][0] !== 10'd96) begin bad++; $display("FAIL basic_lane0_early got=%0d want=96", x[0][0]); end
            end
        end
        total++;
        if (x[0][0] !== 10'd97) begin bad++; $display("FAIL basic_lane0 got=%0d want=97", x[0][0]); end
        total++;
        if (x[2][0] !== 10'd146) begin bad++; $display("FAIL basic_lane2 got=%0d want=146", x[2][0]); end
    endtask

    task automatic test_wrap();
        int bc, errs;
        do_reset();
        level = 2'd3; enable = 1'b1;
        errs = 0;
        for (int t = 1; t <= 460; t++) begin
            pulse_tick(bc);
            for (int n = 0; n < 6; n++)
                for (int k = 0; k < 3; k++)
                    if (x[n][k] !== 10'(m_x[n][k])) errs++;
            if (t == 88) begin
                total++;
                if (x[1][0] !== 10'd32) begin bad++; $display("FAIL wrap_lane1_low got=%0d want=32", x[1][0]); end
            end
            if (t == 89) begin
                total++;
                if (x[1][0] !== 10'd543) begin bad++; $display("FAIL wrap_lane1 got=%0d want=543", x[1][0]); end
            end
            if (t == 447) begin
                total++;
                if (x[0][0] !== 10'd543) begin bad++; $display("FAIL wrap_lane0_high got=%0d want=543", x[0][0]); end
            end
            if (t == 448) begin
                total++;
                if (x[0][0] !== 10'd64) begin bad++; $display("FAIL wrap_lane0 got=%0d want=64", x[0][0]); end
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL wrap_model mismatches got=%0d want=0", errs); end
    endtask

    task automatic test_overrun();
        int bc;
        do_reset();
        level = 2'd3; enable = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        model_frame(1'b1, 3);
        repeat (10) @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%0b want=1", overrun); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL overrun_idle got=%0b want=0", busy); end
        for (int n = 0; n < 6; n++) begin
            total++;
            if (x[n][0] !== 10'(m_x[n][0])) begin
                bad++; $display("FAIL overrun_once lane%0d got=%0d want=%0d", n, x[n][0], m_x[n][0]);
            end
        end
        pulse_tick(bc);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%0b want=1", overrun); end
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%0b want=0", overrun); end
    endtask

    task automatic test_freeze();
        int bc;
        do_reset();
        level = 2'd0; enable = 1'b1;
        pulse_tick(bc);
        enable = 1'b0;
        for (int t = 0; t < 10; t++) begin
            pulse_tick(bc);
            total++;
            if (bc !== 6) begin bad++; $display("FAIL freeze_busy tick%0d got=%0d want=6", t, bc); end
            for (int n = 0; n < 6; n++)
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if (x[n][k] !== 10'(m_x[n][k])) begin
                        bad++; $display("FAIL freeze_x lane%0d car%0d got=%0d want=%0d", n, k, x[n][k], m_x[n][k]);
                    end
                end
        end
        enable = 1'b1;
        for (int t = 0; t < 4; t++) begin
            pulse_tick(bc);
            for (int n = 0; n < 6; n++) begin
                total++;
                if (x[n][1] !== 10'(m_x[n][1])) begin
                    bad++; $display("FAIL freeze_resume tick%0d lane%0d got=%0d want=%0d", t, n, x[n][1], m_x[n][1]);
                end
            end
        end
    endtask

    task automatic test_restart_mid(input bit use_reset);
        int bc;
        do_reset();
        level = 2'd3; enable = 1'b1;
        repeat (5) pulse_tick(bc);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL mid_pre_overrun got=%0b want=1", overrun); end
        if (use_reset) reset = 1'b1; else restart = 1'b1;
        @(posedge clk); #1 reset = 1'b0; restart = 1'b0;
        model_reset();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy rst=%0b got=%0b want=0", use_reset, busy); end
        total++;
        if (overrun !== 1'b0) begin bad++; $display("FAIL mid_overrun rst=%0b got=%0b want=0", use_reset, overrun); end
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 3; k++) begin
                total++;
                if (x[n][k] !== 10'(m_x[n][k])) begin
                    bad++; $display("FAIL mid_x rst=%0b lane%0d car%0d got=%0d want=%0d", use_reset, n, k, x[n][k], m_x[n][k]);
                end
            end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_stay_idle got=%0b want=0", busy); end
        level = 2'd0;
        repeat (3) pulse_tick(bc);
        for (int n = 0; n < 6; n++) begin
            total++;
            if (x[n][0] !== 10'(m_x[n][0])) begin
                bad++; $display("FAIL mid_after lane%0d got=%0d want=%0d", n, x[n][0], m_x[n][0]);
            end
        end
    endtask

    task automatic test_random();
        int bc, errs, inv, lo, cyc, d;
        int ph [3];
        do_reset();
        errs = 0; inv = 0;
        for (int t = 0; t < 2000; t++) begin
            enable = ($urandom_range(0, 7) != 0);
            level  = (t % 250 == 249) ? 2'($urandom_range(0, 3)) : 2'd2;
            pulse_tick(bc);
            if (bc != 6) errs++;
            for (int n = 0; n < 6; n++) begin
                lo  = 96 - LEN[n];
                cyc = 448 + LEN[n];
                for (int k = 0; k < 3; k++) begin
                    if (x[n][k] !== 10'(m_x[n][k])) errs++;
                    if (int'(x[n][k]) < lo || int'(x[n][k]) > 543) inv++;
                    ph[k] = int'(x[n][k]) - lo;
                end
                for (int k = 0; k < 3; k++) begin
                    d = (ph[(k + 1) % 3] - ph[k] + cyc) % cyc;
                    if (d < LEN[n]) inv++;
                end
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_model mismatches got=%0d want=0", errs); end
        total++;
        if (inv != 0) begin bad++; $display("FAIL random_invariant violations got=%0d want=0", inv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_freeze();
        test_restart_mid(1'b0);
        test_restart_mid(1'b1);
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
